// File: rtl/sin_burst_ctrl.sv
// Start/stop sequenced magic-circle sine source with sample-rate divider,
// burst-length counter and a stalling valid/ready sample stream.
module sin_burst_ctrl #(
  parameter int unsigned        DIV_W    = 16,
  parameter int unsigned        LEN_W    = 12,
  parameter logic signed [15:0] INIT_AMP = 16'sd30000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div,
  input  logic [LEN_W-1:0] burst_len,
  input  logic [2:0]       shift,
  input  logic [1:0]       amp_shift,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   div_cnt;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   tick_cnt;
  logic [LEN_W-1:0]   tick_cnt_nx;
  logic [3:0]         k_q;
  logic [1:0]         amp_q;
  logic signed [15:0] s;
  logic signed [15:0] c;
  logic signed [15:0] s_nx;
  logic signed [15:0] c_nx;
  logic [7:0]         code;
  logic               accept;
  logic               tick_due;
  logic               tick;

  always_comb begin
    s_nx        = s + (c >>> k_q);
    c_nx        = c - (s_nx >>> k_q);
    // attenuation and the byte select fold into one arithmetic shift;
    // flipping the MSB turns two's complement into offset binary
    code        = 8'(s_nx >>> ({2'b00, amp_q} + 4'd8)) ^ 8'h80;
    tick_cnt_nx = tick_cnt + 1'b1;
    accept      = m_valid && m_ready;
    tick_due    = (state == RUN) && (div_cnt == div_q);
    tick        = tick_due && (!m_valid || m_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      div_q    <= '0;
      div_cnt  <= '0;
      len_q    <= '0;
      tick_cnt <= '0;
      k_q      <= 4'd1;
      amp_q    <= '0;
      s        <= '0;
      c        <= INIT_AMP;
      m_data   <= 8'h80;
      m_valid  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            div_q    <= div;
            len_q    <= burst_len;
            k_q      <= {1'b0, shift} + 4'd1;
            amp_q    <= amp_shift;
            s        <= '0;
            c        <= INIT_AMP;
            div_cnt  <= '0;
            tick_cnt <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state <= DRAIN;
            if (accept) m_valid <= 1'b0;
          end else if (tick) begin
            s        <= s_nx;
            c        <= c_nx;
            m_data   <= code;
            m_valid  <= 1'b1;
            div_cnt  <= '0;
            tick_cnt <= tick_cnt_nx;
            if (len_q != '0 && tick_cnt_nx == len_q) state <= DRAIN;
          end else begin
            // a due tick blocked by backpressure parks the divider at div
            if (!tick_due) div_cnt <= div_cnt + 1'b1;
            if (accept) m_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (!m_valid || m_ready) begin
            m_valid <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sin_burst_ctrl.md
# sin_burst_ctrl

Sequenced sine-source controller for the oscilloscope's internal test/calibration generator. Wraps a 16-bit recursive (magic-circle) sine oscillator with a start/stop FSM, a programmable sample-rate divider, a burst-length counter and a valid/ready output stream. Downstream consumers (sample buffer, DAC driver) receive 8-bit offset-binary samples with no drops. Backpressure stalls the oscillator instead of discarding samples.

## Interface
- DIV_W, 16: width of the sample-rate divider.
- LEN_W, 12: width of the burst-length counter.
- INIT_AMP, 16'd30000: cosine state loaded on start; sets output amplitude.
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle start request; honoured only in IDLE.
- stop  in  1  single-cycle stop request; honoured only in RUN.
- div  in  DIV_W  tick period minus one; one oscillator step every div+1 cycles. Latched at start.
- burst_len  in  LEN_W  samples per burst; 0 = continuous until stop. Latched at start.
- shift  in  3  frequency select; oscillator shift k = shift+1 (1..8). Latched at start.
- amp_shift  in  2  output attenuation; sine state arithmetic-shifted right by amp_shift before truncation. Latched at start.
- m_data  out  8  sample, offset binary (0x80 = zero).
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accept; transfer when m_valid && m_ready.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse on return to IDLE from a burst or a stop.

## Operation
- State: s, c signed 16-bit; div_cnt DIV_W; tick_cnt LEN_W; FSM IDLE, RUN, DRAIN.
- IDLE: busy=0. start=1 -> latch div/burst_len/shift/amp_shift; s=0, c=INIT_AMP; div_cnt=0; tick_cnt=0; -> RUN.
- Oscillator step on tick: s' = s + (c >>> k); c' = c − (s' >>> k) (uses updated s'); 16-bit wrap, no saturation.
- Output on tick: t = s' >>> amp_shift; m_data = {~t[15], t[14:8]}; m_valid=1.
- RUN: div_cnt increments each cycle; at div_cnt==div a tick is due. Tick fires only if m_valid==0 or m_ready==1 that cycle; otherwise div_cnt holds at div (stall). On tick: div_cnt=0, tick_cnt+1.
- Burst end: burst_len≠0 and tick_cnt reaches burst_len -> -> DRAIN (no further ticks).
- stop in RUN -> DRAIN same edge; a tick due in that same cycle is suppressed.
- DRAIN: hold m_data/m_valid until accepted (or exit immediately if m_valid==0); then m_valid=0, done=1 for one cycle, -> IDLE.
- start in RUN/DRAIN ignored; stop in IDLE/DRAIN ignored; start and stop together in IDLE -> start.
- m_valid drops after acceptance when no new tick coincides; simultaneous accept and tick reloads m_data, m_valid stays 1.

## Timing
- Reset (async, immediate): FSM=IDLE, m_data=0x80, m_valid=0, busy=0, done=0, s=0, c=INIT_AMP, counters 0. Reset mid-burst aborts with no done pulse.
- start sampled at edge E0 -> busy=1 after E0; first tick at cycle div after E0; m_valid=1 after edge E0+div+1.
- Unstalled rate: one sample per div+1 cycles; div=0 with m_ready held high gives one sample per cycle.
- done asserted the cycle after the final accept; busy falls with done.

## Test plan
- div=0, shift=4 (k=5), amp_shift=0, burst_len=3, m_ready=1 -> m_data 0x83, 0x87, 0x8A on three consecutive cycles (c: 30000→29971→29913), then done pulse, busy=0.
- Same but amp_shift=1 -> first sample 0x81 (468>>8=1); div=3 -> samples spaced exactly 4 cycles, first valid 4 cycles after start edge.
- Backpressure: div=0, m_ready low 10 cycles after first valid -> m_data held at 0x83, div_cnt frozen, no step; release -> 0x87 next, no gaps or duplicates.
- burst_len=0, k=5, run 210 ticks -> peak m_data in 0xF0..0xFA near tick 50, trough 0x06..0x10 near tick 150, returns through 0x80 region near tick 201; stop -> pending sample delivered, done pulse.
- stop and start together in RUN; start during DRAIN -> start ignored, one done pulse, new start in IDLE restarts from s=0 (first sample 0x83).
- Assert rst_n low mid-burst with m_valid=1 -> m_valid=0, m_data=0x80, busy=0 immediately, no done pulse; start after release behaves as fresh burst.
